// File: rtl/opll_bus_sequencer.sv
// opll_bus_sequencer: queues whole OPLL register writes and replays each one
// as an address phase and a data phase on the CS_n/WR_n/A0/D bus. Each phase
// is followed by the OPLL post-write wait time.
module opll_bus_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_CHIPS   = 1,
    parameter int CHIP_W      = 1,
    parameter int WR_PULSE    = 4,
    parameter int ADDR_WAIT   = 12,
    parameter int DATA_WAIT   = 84,
    parameter int SKIP_REPEAT = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [CHIP_W-1:0]             i_chip,
    input  logic [7:0]                    i_reg,
    input  logic [7:0]                    i_data,
    output logic [NUM_CHIPS-1:0]          o_cs_n,
    output logic                          o_wr_n,
    output logic                          o_a0,
    output logic [7:0]                    o_d,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int MAX_T     = (WR_PULSE > ADDR_WAIT) ?
                               ((WR_PULSE > DATA_WAIT) ? WR_PULSE : DATA_WAIT) :
                               ((ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT);
    localparam int CNT_W     = $clog2(MAX_T) + 1;
    localparam int CHIP_SPAN = 1 << CHIP_W;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] AWAIT_LD = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DWAIT_LD = CNT_W'(DATA_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APULSE = 3'd1,
        AWAIT  = 3'd2,
        DPULSE = 3'd3,
        DWAIT  = 3'd4
    } state_t;

    // Chip indices at or above NUM_CHIPS are consumed without touching any CS_n.
    function automatic logic chip_in_range(input logic [CHIP_W-1:0] chip);
        return (32'(chip) < NUM_CHIPS);
    endfunction

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               pop_s, push_s, skip_s;

    logic [CHIP_W+15:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [CHIP_W-1:0]  head_chip_s;
    logic [7:0]         head_reg_s, head_data_s;

    logic [CHIP_W-1:0]  cur_chip_r;
    logic [7:0]         cur_reg_r, cur_data_r;
    logic [7:0]         last_reg_r [CHIP_SPAN];
    logic [CHIP_SPAN-1:0] last_vld_r;
    logic [NUM_CHIPS-1:0] cs_sel_s;

    // A pop frees no room this cycle because ready comes from the registered level.
    assign push_s  = i_valid && (level_r != LVL_FULL);
    assign o_ready = (level_r != LVL_FULL);
    assign o_level = level_r;
    assign {head_chip_s, head_reg_s, head_data_s} = fifo_mem_r[rd_ptr_r];

    // Decide whether the head entry can skip its address phase.
    always_comb begin
        skip_s = 1'b0;
        if ((SKIP_REPEAT != 0) && chip_in_range(head_chip_s) &&
            last_vld_r[head_chip_s] && (last_reg_r[head_chip_s] == head_reg_s)) begin
            skip_s = 1'b1;
        end else begin
            skip_s = 1'b0;
        end
    end

    // Active-low select pattern for the latched chip (all high when out of range).
    always_comb begin
        cs_sel_s = {NUM_CHIPS{1'b1}};
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (32'(cur_chip_r) == i) begin
                cs_sel_s[i] = 1'b0;
            end else begin
                cs_sel_s[i] = 1'b1;
            end
        end
    end

    // Next-state logic; one down-counter times every state.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (level_r != LVL_ZERO) begin
                    pop_s        = 1'b1;
                    state_next_s = skip_s ? DPULSE : APULSE;
                    cnt_next_s   = PULSE_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            APULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = AWAIT;
                    cnt_next_s   = AWAIT_LD;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            AWAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = DPULSE;
                    cnt_next_s   = PULSE_LD;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            DPULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = DWAIT;
                    cnt_next_s   = DWAIT_LD;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            DWAIT: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end else if (level_r != LVL_ZERO) begin
                    // Chain straight into the next entry without an IDLE cycle.
                    pop_s        = 1'b1;
                    state_next_s = skip_s ? DPULSE : APULSE;
                    cnt_next_s   = PULSE_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {i_chip, i_reg, i_data};
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Latch the popped entry and remember the last register addressed per chip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_chip_r <= {CHIP_W{1'b0}};
            cur_reg_r  <= 8'h00;
            cur_data_r <= 8'h00;
            last_vld_r <= {CHIP_SPAN{1'b0}};
            for (int i = 0; i < CHIP_SPAN; i++) begin
                last_reg_r[i] <= 8'h00;
            end
        end else if (pop_s) begin
            cur_chip_r <= head_chip_s;
            cur_reg_r  <= head_reg_s;
            cur_data_r <= head_data_s;
            if (!skip_s && chip_in_range(head_chip_s)) begin
                last_reg_r[head_chip_s] <= head_reg_s;
                last_vld_r[head_chip_s] <= 1'b1;
            end
        end
    end

    // Registered bus outputs, driven one clock behind the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cs_n <= {NUM_CHIPS{1'b1}};
            o_wr_n <= 1'b1;
            o_a0   <= 1'b0;
            o_d    <= 8'h00;
            o_busy <= 1'b0;
        end else begin
            o_busy <= (state_r != IDLE) || (level_r != LVL_ZERO);
            case (state_r)
                APULSE: begin
                    o_cs_n <= cs_sel_s;
                    o_wr_n <= 1'b0;
                    o_a0   <= 1'b0;
                    o_d    <= cur_reg_r;
                end
                DPULSE: begin
                    o_cs_n <= cs_sel_s;
                    o_wr_n <= 1'b0;
                    o_a0   <= 1'b1;
                    o_d    <= cur_data_r;
                end
                default: begin
                    o_cs_n <= {NUM_CHIPS{1'b1}};
                    o_wr_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opll_bus_sequencer.sv
// Testbench for opll_bus_sequencer: random and directed register writes are
// checked against a slot-scheduling reference model of the bus phases.
module tb_opll_bus_sequencer;

    localparam int FD   = 4;
    localparam int NC   = 2;
    localparam int CW   = 2;
    localparam int WRP  = 4;
    localparam int AW   = 12;
    localparam int DW   = 84;
    localparam int SKIP = 1;
    localparam int FULL_SLOT = 2 * WRP + AW + DW;
    localparam int SKIP_SLOT = WRP + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [CW-1:0] i_chip = '0;
    logic [7:0]    i_reg = 8'h00;
    logic [7:0]    i_data = 8'h00;
    logic [NC-1:0] o_cs_n;
    logic          o_wr_n, o_a0, o_busy;
    logic [7:0]    o_d;
    logic [$clog2(FD):0] o_level;

    opll_bus_sequencer #(
        .FIFO_DEPTH(FD), .NUM_CHIPS(NC), .CHIP_W(CW), .WR_PULSE(WRP),
        .ADDR_WAIT(AW), .DATA_WAIT(DW), .SKIP_REPEAT(SKIP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_chip(i_chip), .i_reg(i_reg), .i_data(i_data), .o_cs_n(o_cs_n),
        .o_wr_n(o_wr_n), .o_a0(o_a0), .o_d(o_d), .o_busy(o_busy), .o_level(o_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each write occupies one slot; a slot starts two edges
    // after the push, or when the previous slot ends, whichever is later.
    typedef struct packed {
        logic [31:0] start;
        logic [1:0]  cs;
        logic        a0;
        logic [7:0]  d;
    } phase_t;

    phase_t     exp_q[$];
    bit         m_vld [4];
    logic [7:0] m_reg [4];
    int         next_free = 0;
    int         max_level = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 1'b0;
            m_reg[i] = 8'h00;
        end
        next_free = 0;
    endtask

    task automatic model_push(input int acc_edge, input logic [1:0] chip,
                              input logic [7:0] rg, input logic [7:0] dt);
        bit         inr;
        bit         skip;
        int         start;
        logic [1:0] one;
        logic [1:0] cs;
        one   = 2'b01;
        inr   = (chip < NC);
        skip  = inr && m_vld[chip] && (m_reg[chip] == rg);
        start = (acc_edge + 2 > next_free) ? acc_edge + 2 : next_free;
        cs    = inr ? ~(one << chip) : 2'b11;
        if (!skip) begin
            exp_q.push_back('{32'(start), cs, 1'b0, rg});
            exp_q.push_back('{32'(start + WRP + AW), cs, 1'b1, dt});
            next_free = start + FULL_SLOT;
            if (inr) begin
                m_vld[chip] = 1'b1;
                m_reg[chip] = rg;
            end
        end else begin
            exp_q.push_back('{32'(start), cs, 1'b1, dt});
            next_free = start + SKIP_SLOT;
        end
    endtask

    // Bus monitor: collects each strobe-low run and compares it with the model.
    initial begin
        bit         in_ph;
        int         ph_start, ph_len;
        logic [1:0] ph_cs;
        logic       ph_a0;
        logic [7:0] ph_d;
        phase_t     e;
        in_ph = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                in_ph = 1'b0;
            end else begin
                if (int'(o_level) > max_level) max_level = int'(o_level);
                if (!in_ph && o_wr_n == 1'b0) begin
                    in_ph = 1'b1; ph_start = cyc; ph_len = 1;
                    ph_cs = o_cs_n; ph_a0 = o_a0; ph_d = o_d;
                end else if (in_ph && o_wr_n == 1'b0) begin
                    ph_len++;
                end else if (in_ph) begin
                    in_ph = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_val("spurious_phase", 32'(ph_start), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("phase_start", 32'(ph_start), e.start);
                        check_val("phase_len",   32'(ph_len),   32'(WRP));
                        check_val("phase_cs_n",  32'(ph_cs),    32'(e.cs));
                        check_val("phase_a0",    32'(ph_a0),    32'(e.a0));
                        check_val("phase_d",     32'(ph_d),     32'(e.d));
                    end
                end
            end
        end
    end

    // Drive one write and hold it until accepted; called and returns at a negedge.
    task automatic push_write(input logic [1:0] chip, input logic [7:0] rg, input logic [7:0] dt);
        int waited;
        bit acc;
        int acc_edge;
        waited = 0; acc = 1'b0; acc_edge = 0;
        i_valid = 1'b1; i_chip = chip; i_reg = rg; i_data = dt;
        while (!acc && waited < 3000) begin
            if (o_ready) begin
                acc = 1'b1;
                acc_edge = cyc + 1;
            end
            @(negedge clk);
            waited++;
        end
        i_valid = 1'b0;
        check_val("push_accept", 32'(acc), 32'd1);
        if (acc) model_push(acc_edge, chip, rg, dt);
    endtask

    // Wait for the sequencer to drain and check when o_busy falls.
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_fall", 32'(cyc), 32'(next_free));
        check_val("pending_phases", 32'(exp_q.size()), 32'd0);
        check_val("idle_level", 32'(o_level), 32'd0);
    endtask

    initial begin
        int  gap;
        bit  seen;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_cs_n",  32'(o_cs_n),  32'h3);
        check_val("rst_wr_n",  32'(o_wr_n),  32'd1);
        check_val("rst_a0",    32'(o_a0),    32'd0);
        check_val("rst_d",     32'(o_d),     32'h00);
        check_val("rst_busy",  32'(o_busy),  32'd0);
        check_val("rst_level", 32'(o_level), 32'd0);
        check_val("rst_ready", 32'(o_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single default write.
        push_write(2'd0, 8'h10, 8'h55);
        wait_idle();

        // Repeated register on one chip: second write drops its address phase.
        push_write(2'd0, 8'h20, 8'h01);
        push_write(2'd0, 8'h20, 8'h02);
        wait_idle();

        // Second chip and an out-of-range chip index.
        push_write(2'd1, 8'h30, 8'hA1);
        push_write(2'd3, 8'h31, 8'hA2);
        wait_idle();

        // Burst of six into a four-deep FIFO.
        for (int i = 0; i < 6; i++) begin
            push_write(2'(i % 2), 8'(8'h40 + i), 8'(8'hB0 + i));
            if (i == 4) begin
                check_val("burst_level_full", 32'(o_level), 32'd4);
                check_val("burst_ready_low",  32'(o_ready), 32'd0);
            end
        end
        wait_idle();

        // Reset during a data pulse (reg 0x44 on chip 0 is a skipped write here).
        push_write(2'd0, 8'h44, 8'hC0);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (o_wr_n == 1'b0 && o_a0 == 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check_val("dpulse_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_wr_n",  32'(o_wr_n),  32'd1);
        check_val("arst_cs_n",  32'(o_cs_n),  32'h3);
        check_val("arst_level", 32'(o_level), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(o_ready), 32'd1);
        check_val("post_rst_busy",  32'(o_busy),  32'd0);
        push_write(2'd0, 8'h44, 8'hC1);
        wait_idle();

        // Random interleaved pushes exercising pointer wrap and skips.
        for (int i = 0; i < 14; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 130));
            repeat (gap) @(negedge clk);
            push_write(2'($urandom_range(0, 3)), 8'(8'h50 + $urandom_range(0, 2)),
                       8'($urandom_range(0, 255)));
        end
        wait_idle();
        check_val("level_bound", 32'(max_level <= FD), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
